fpu_flags_csr: RTL
==================

# fpu_flags_csr

Consumer end of the FPU exception-flag path. The block takes per-result flags (OF, UF, IX, IV, DZ) and the Zero/Inf classification produced by the exception stage. It accumulates them into the sticky RISC-V `fflags` register and holds the rounding mode `frm`. It serves core CSR accesses through a request/grant/response handshake that is ordered behind in-flight FPU operations.

## Interface
Parameters:
- C_CNT, 16, width of the saturating exceptional-result counter
- C_RM, 3, rounding-mode width

Ports:
- Clk_CI  in  1  clock; all state updates on the rising edge
- Rst_RI  in  1  synchronous, active-high reset
- Valid_SI  in  1  FPU result retires this cycle; flag inputs are sampled only when it is high
- IV_SI, DZ_SI, OF_SI, UF_SI, IX_SI  in  1 each  per-result exception flags
- Zero_SI, Inf_SI  in  1 each  per-result classification
- Fpu_busy_SI  in  1  an FPU operation is in flight and has not yet reached Valid_SI
- Csr_req_SI  in  1  CSR access request; held stable until granted
- Csr_op_SI  in  2  00 read, 01 write, 10 set, 11 clear
- Csr_addr_SI  in  2  00 exception counter, 01 fflags, 10 frm, 11 fcsr
- Csr_wdata_DI  in  C_CNT  write/set/clear data; low bits used per address
- Csr_gnt_SO  out  1  request accepted this cycle
- Csr_rvalid_SO  out  1  response valid; exactly one cycle after the grant
- Csr_rdata_DO  out  C_CNT  old value of the addressed register, zero-extended
- Fflags_DO  out  5  {NV,DZ,OF,UF,NX}, sticky
- Rm_DO  out  C_RM  current frm
- Rm_illegal_SO  out  1  frm is 5, 6 or 7
- Last_zero_SO, Last_inf_SO  out  1 each  classification of the most recent valid result

## Operation
- Sticky accumulate: on Valid_SI, fflags |= {IV,DZ,OF,UF,IX}. Last_zero/Last_inf load Zero_SI/Inf_SI.
- Counter: increments by 1 on each Valid_SI with any of the five flags set. It saturates at 2^C_CNT-1.
- FSM states:
  - IDLE: with Csr_req_SI high and Fpu_busy_SI low, assert Csr_gnt_SO combinationally, perform the op and go to RESP. With Csr_req_SI high and Fpu_busy_SI high, go to WAIT.
  - WAIT: stay while Fpu_busy_SI is high. On the first cycle Fpu_busy_SI is low, grant and perform the op (Csr_req_SI still high), then go to RESP. If the request drops while waiting, return to IDLE without granting.
  - RESP: assert Csr_rvalid_SO with the captured data and return to IDLE. No grant is issued in RESP, so back-to-back grants are at least 2 cycles apart.
- Op semantics at the grant cycle, where v is the old value:
  - read: no change
  - write: new = wdata
  - set: new = v | wdata
  - clear: new = v & ~wdata
- Field mapping:
  - fflags: bits [4:0]
  - frm: bits [2:0]
  - fcsr: bits [7:5] map to frm and bits [4:0] to fflags
  - counter: bits [C_CNT-1:0]
  - Unused bits read as 0.
- Reads and all ops capture the old value at the grant cycle into rdata.
- Simultaneous Valid_SI and a granted fflags/fcsr/counter op: apply the CSR op first, then OR in the new flags or apply the counter increment. A write or clear never loses flags retiring in the same cycle. The captured rdata excludes them.
- frm accepts any 3-bit value. Rm_illegal_SO is combinational from the stored frm.

## Timing
- Reset values (state after the first edge with Rst_RI high):
  - FSM IDLE
  - fflags, counter and frm all 0
  - Fflags_DO, Rm_DO and Rm_illegal_SO all 0
  - Csr_gnt_SO, Csr_rvalid_SO and Csr_rdata_DO all 0
  - Last_zero_SO and Last_inf_SO both 0
- Reset mid-transaction aborts it. No rvalid is issued for a grant that occurred on the reset cycle.
- Flag latency: Valid_SI at edge N is visible on Fflags_DO after edge N.
- CSR latency: grant in cycle N, register update at edge N+1, Csr_rvalid_SO high during cycle N+1.
- Csr_rdata_DO holds its last value while rvalid is low.

## Test plan
- Reset, then Valid_SI with OF=1,IX=1 and then Valid_SI with IV=1 -> Fflags_DO = 5'b10101, counter = 2, read of addr 00 returns 2.
- Csr clear of fflags (wdata 5'b11111) in the same cycle as Valid_SI with UF=1 -> rdata = old flags, Fflags_DO = 5'b00010 after the edge.
- Write fcsr with wdata 8'hE3 -> Rm_DO = 3'b111, Rm_illegal_SO = 1, Fflags_DO = 5'b00011. Read of frm returns 7.
- Csr_req_SI with Fpu_busy_SI high for 4 cycles -> no grant for those 4 cycles. Grant on the 5th cycle, rvalid on the 6th.
- Preload counter with 16'hFFFF, then 3 flagged results -> counter stays at 16'hFFFF.
- Assert Rst_RI in the cycle after a grant -> Csr_rvalid_SO = 0 and all registers = 0 on the following cycle.

Source files
------------

// File: rtl/fpu_flags_csr.sv
// -----------------------------------------------------------------------------
// fpu_flags_csr
// Consumer end of the FPU exception-flag path. Accumulates per-result flags
// into the sticky RISC-V fflags register, counts exceptional results in a
// saturating counter, holds the rounding mode frm, and serves core CSR
// accesses through a request/grant/response handshake that waits behind
// in-flight FPU operations.
//
// Ports:
//   Clk_CI, Rst_RI            clock, synchronous active-high reset
//   Valid_SI                  an FPU result retires this cycle
//   IV/DZ/OF/UF/IX_SI         per-result exception flags
//   Zero_SI, Inf_SI           per-result classification
//   Fpu_busy_SI               an FPU op is in flight, CSR access must wait
//   Csr_req_SI/op/addr/wdata  CSR request (op: rd/wr/set/clr,
//                             addr: counter/fflags/frm/fcsr)
//   Csr_gnt_SO                request accepted this cycle (combinational)
//   Csr_rvalid_SO/rdata_DO    response one cycle after grant, old value
//   Fflags_DO, Rm_DO          current fflags {NV,DZ,OF,UF,NX} and frm
//   Rm_illegal_SO             frm holds a reserved encoding (5..7)
//   Last_zero_SO/Last_inf_SO  classification of the latest valid result
// -----------------------------------------------------------------------------
module fpu_flags_csr #(
   parameter int unsigned C_CNT = 16,
   parameter int unsigned C_RM  = 3
) (
   input  logic             Clk_CI,
   input  logic             Rst_RI,
   input  logic             Valid_SI,
   input  logic             IV_SI,
   input  logic             DZ_SI,
   input  logic             OF_SI,
   input  logic             UF_SI,
   input  logic             IX_SI,
   input  logic             Zero_SI,
   input  logic             Inf_SI,
   input  logic             Fpu_busy_SI,
   input  logic             Csr_req_SI,
   input  logic [1:0]       Csr_op_SI,
   input  logic [1:0]       Csr_addr_SI,
   input  logic [C_CNT-1:0] Csr_wdata_DI,
   output logic             Csr_gnt_SO,
   output logic             Csr_rvalid_SO,
   output logic [C_CNT-1:0] Csr_rdata_DO,
   output logic [4:0]       Fflags_DO,
   output logic [C_RM-1:0]  Rm_DO,
   output logic             Rm_illegal_SO,
   output logic             Last_zero_SO,
   output logic             Last_inf_SO
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [4:0]       fflags_q, fflags_d;
   logic [C_RM-1:0]  frm_q, frm_d;
   logic [C_CNT-1:0] cnt_q, cnt_d;
   logic             last_zero_q, last_zero_d;
   logic             last_inf_q, last_inf_d;
   logic             rvalid_q, rvalid_d;
   logic [C_CNT-1:0] rdata_q, rdata_d;

   logic             gnt_s;
   logic [4:0]       flags_s;
   logic [C_CNT-1:0] old_s;
   logic [C_CNT-1:0] new_s;
   logic [4:0]       fflags_csr_s;
   logic [C_CNT-1:0] cnt_csr_s;

   assign flags_s = {IV_SI, DZ_SI, OF_SI, UF_SI, IX_SI};

   // Grant in IDLE or WAIT once no FPU op is in flight; never during reset so
   // a reset-cycle grant cannot produce a response.
   always_comb begin
      gnt_s = 1'b0;
      if (!Rst_RI && Csr_req_SI && !Fpu_busy_SI &&
          ((state_q == ST_IDLE) || (state_q == ST_WAIT))) begin
         gnt_s = 1'b1;
      end else begin
         gnt_s = 1'b0;
      end
   end

   // Handshake sequencing: IDLE -> (WAIT) -> RESP -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (Csr_req_SI) begin
               state_d = Fpu_busy_SI ? ST_WAIT : ST_RESP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!Csr_req_SI) begin
               state_d = ST_IDLE;
            end else if (Fpu_busy_SI) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Old value of the addressed CSR, zero-extended to the data width.
   always_comb begin
      old_s = {C_CNT{1'b0}};
      case (Csr_addr_SI)
         2'b00: old_s = cnt_q;
         2'b01: old_s[4:0] = fflags_q;
         2'b10: old_s[C_RM-1:0] = frm_q;
         2'b11: begin
            old_s[4:0]      = fflags_q;
            old_s[5 +: C_RM] = frm_q;
         end
         default: old_s = {C_CNT{1'b0}};
      endcase
   end

   // Read-modify-write result of the requested op.
   always_comb begin
      new_s = old_s;
      case (Csr_op_SI)
         2'b00:   new_s = old_s;
         2'b01:   new_s = Csr_wdata_DI;
         2'b10:   new_s = old_s | Csr_wdata_DI;
         2'b11:   new_s = old_s & ~Csr_wdata_DI;
         default: new_s = old_s;
      endcase
   end

   // CSR op applied first; retiring flags and the counter increment are merged
   // on top so a same-cycle write/clear never drops a freshly raised flag.
   always_comb begin
      fflags_csr_s = fflags_q;
      frm_d        = frm_q;
      cnt_csr_s    = cnt_q;
      if (gnt_s) begin
         case (Csr_addr_SI)
            2'b00: cnt_csr_s = new_s;
            2'b01: fflags_csr_s = new_s[4:0];
            2'b10: frm_d = new_s[C_RM-1:0];
            2'b11: begin
               fflags_csr_s = new_s[4:0];
               frm_d        = new_s[5 +: C_RM];
            end
            default: cnt_csr_s = cnt_q;
         endcase
      end else begin
         fflags_csr_s = fflags_q;
         frm_d        = frm_q;
         cnt_csr_s    = cnt_q;
      end

      fflags_d    = fflags_csr_s;
      cnt_d       = cnt_csr_s;
      last_zero_d = last_zero_q;
      last_inf_d  = last_inf_q;
      if (Valid_SI) begin
         fflags_d    = fflags_csr_s | flags_s;
         last_zero_d = Zero_SI;
         last_inf_d  = Inf_SI;
         if ((|flags_s) && (cnt_csr_s != {C_CNT{1'b1}})) begin
            cnt_d = cnt_csr_s + {{(C_CNT-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_csr_s;
         end
      end else begin
         fflags_d = fflags_csr_s;
         cnt_d    = cnt_csr_s;
      end
   end

   // Response: pulse one cycle after the grant, data held between responses.
   always_comb begin
      rvalid_d = gnt_s;
      if (gnt_s) begin
         rdata_d = old_s;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state_q     <= ST_IDLE;
         fflags_q    <= 5'b00000;
         frm_q       <= {C_RM{1'b0}};
         cnt_q       <= {C_CNT{1'b0}};
         last_zero_q <= 1'b0;
         last_inf_q  <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= {C_CNT{1'b0}};
      end else begin
         state_q     <= state_d;
         fflags_q    <= fflags_d;
         frm_q       <= frm_d;
         cnt_q       <= cnt_d;
         last_zero_q <= last_zero_d;
         last_inf_q  <= last_inf_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
      end
   end

   assign Csr_gnt_SO    = gnt_s;
   assign Csr_rvalid_SO = rvalid_q;
   assign Csr_rdata_DO  = rdata_q;
   assign Fflags_DO     = fflags_q;
   assign Rm_DO         = frm_q;
   assign Rm_illegal_SO = (frm_q >= C_RM'(3'd5));
   assign Last_zero_SO  = last_zero_q;
   assign Last_inf_SO   = last_inf_q;

endmodule
